// File: rtl/cfg_reg_arbiter.sv
// cfg_reg_arbiter: round-robin A/B write arbiter into a shadow config bank, committed atomically to reg_out (ports: clk, rst, a_/b_ req/addr/data/ack/err, reg_out, commit_done, busy)
module cfg_reg_arbiter #(
  parameter int                 NUM_REGS    = 5,
  parameter int                 ADDR_W      = 7,
  parameter int                 DATA_W      = 8,
  parameter logic [ADDR_W-1:0]  COMMIT_ADDR = 7'h7F
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         a_req,
  input  logic [ADDR_W-1:0]            a_addr,
  input  logic [DATA_W-1:0]            a_data,
  output logic                         a_ack,
  output logic                         a_err,
  input  logic                         b_req,
  input  logic [ADDR_W-1:0]            b_addr,
  input  logic [DATA_W-1:0]            b_data,
  output logic                         b_ack,
  output logic                         b_err,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  output logic                         commit_done,
  output logic                         busy
);
  typedef enum logic [1:0] {IDLE, WRITE, COMMIT} state_t;
  state_t                       state, state_nx;
  logic                         sel_b, rr_last_b, pick_b, in_rng, is_commit, ok, bad;
  logic [ADDR_W-1:0]            addr_q;
  logic [DATA_W-1:0]            data_q;
  logic [NUM_REGS*DATA_W-1:0]   shadow;
  assign pick_b    = b_req & (~a_req | ~rr_last_b);
  assign in_rng    = addr_q < ADDR_W'(NUM_REGS);
  assign is_commit = addr_q == COMMIT_ADDR;
  always_comb begin
    state_nx    = state == IDLE ? ((a_req | b_req) ? WRITE : IDLE)
                : (state == WRITE && is_commit) ? COMMIT : IDLE;
    ok          = state == WRITE && (in_rng || is_commit);
    bad         = state == WRITE && !(in_rng || is_commit);
    a_ack       = ok & ~sel_b;
    b_ack       = ok & sel_b;
    a_err       = bad & ~sel_b;
    b_err       = bad & sel_b;
    commit_done = state == COMMIT;
    busy        = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel_b     <= 1'b0;
      rr_last_b <= 1'b1;
      addr_q    <= '0;
      data_q    <= '0;
      shadow    <= '0;
      reg_out   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (a_req | b_req)) begin
        sel_b  <= pick_b;
        addr_q <= pick_b ? b_addr : a_addr;
        data_q <= pick_b ? b_data : a_data;
      end
      if (state == WRITE) begin
        rr_last_b <= sel_b;
        for (int k = 0; k < NUM_REGS; k++)
          if (addr_q == ADDR_W'(k)) shadow[k*DATA_W +: DATA_W] <= data_q;
      end
      if (state == COMMIT) reg_out <= shadow;
    end
  end
endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// tb_cfg_reg_arbiter: table-driven and directed checks of the A/B config register arbiter
module tb_cfg_reg_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        a_req = 1'b0, b_req = 1'b0;
  logic [6:0]  a_addr = '0, b_addr = '0;
  logic [7:0]  a_data = '0, b_data = '0;
  logic        a_ack, a_err, b_ack, b_err, commit_done, busy;
  logic [39:0] reg_out;
  int          checks = 0, errors = 0;

  typedef struct {
    logic        do_rst;
    logic        ar;
    logic [6:0]  aa;
    logic [7:0]  ad;
    logic        br;
    logic [6:0]  ba;
    logic [7:0]  bd;
    logic        ea_ack, ea_err, eb_ack, eb_err;
    logic        b_first;
    int          commits;
    logic [39:0] exp_reg;
  } vec_t;

  cfg_reg_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack), .a_err(a_err),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack), .b_err(b_err),
    .reg_out(reg_out), .commit_done(commit_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic ga_ack, ga_err, gb_ack, gb_err, da, db, spur;
    int   first, commits;
    ga_ack = 0; ga_err = 0; gb_ack = 0; gb_err = 0; da = 0; db = 0; spur = 0;
    first = -1; commits = 0;
    if (v.do_rst) do_reset();
    @(negedge clk);
    a_req = v.ar; a_addr = v.aa; a_data = v.ad;
    b_req = v.br; b_addr = v.ba; b_data = v.bd;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (da) begin a_req = 1'b0; da = 0; end
      if (db) begin b_req = 1'b0; db = 0; end
      if ((a_ack && a_err) || (b_ack && b_err) || (!a_req && (a_ack || a_err)) || (!b_req && (b_ack || b_err)))
        spur = 1;
      if (a_req && (a_ack || a_err)) begin
        ga_ack |= a_ack; ga_err |= a_err; da = 1;
        if (first < 0) first = 0;
      end
      if (b_req && (b_ack || b_err)) begin
        gb_ack |= b_ack; gb_err |= b_err; db = 1;
        if (first < 0) first = 1;
      end
      if (commit_done) commits++;
    end
    chk($sformatf("v%0d a_ack", idx), 64'(ga_ack), 64'(v.ea_ack));
    chk($sformatf("v%0d a_err", idx), 64'(ga_err), 64'(v.ea_err));
    chk($sformatf("v%0d b_ack", idx), 64'(gb_ack), 64'(v.eb_ack));
    chk($sformatf("v%0d b_err", idx), 64'(gb_err), 64'(v.eb_err));
    chk($sformatf("v%0d handshake_rules", idx), 64'(spur), 64'(0));
    chk($sformatf("v%0d commit_pulses", idx), 64'(commits), 64'(v.commits));
    chk($sformatf("v%0d reg_out", idx), 64'(reg_out), 64'(v.exp_reg));
    if (v.ar && v.br) chk($sformatf("v%0d b_first", idx), 64'(first), 64'(v.b_first));
  endtask

  initial begin
    vec_t vt[12];
    vec_t cv;
    int   g[$];
    int   na, nb;
    logic pa, pb, stay;
    //          rst   ar    aa     ad     br    ba     bd     aack  aerr  back  berr  bfirst cm reg
    vt[0]  = '{1'b1, 1'b1, 7'h02, 8'hA5, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 40'h0};
    vt[1]  = '{1'b0, 1'b1, 7'h7F, 8'h00, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 40'h00_00_A5_00_00};
    vt[2]  = '{1'b0, 1'b1, 7'h04, 8'h80, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 40'h00_00_A5_00_00};
    vt[3]  = '{1'b1, 1'b1, 7'h01, 8'h11, 1'b1, 7'h01, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 40'h0};
    vt[4]  = '{1'b0, 1'b1, 7'h7F, 8'h00, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 40'h00_00_00_22_00};
    vt[5]  = '{1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 7'h05, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 40'h00_00_00_22_00};
    vt[6]  = '{1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 7'h40, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 40'h00_00_00_22_00};
    vt[7]  = '{1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 7'h7F, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 40'h00_00_00_22_00};
    vt[8]  = '{1'b0, 1'b1, 7'h00, 8'h01, 1'b1, 7'h7F, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 40'h00_00_00_22_01};
    vt[9]  = '{1'b0, 1'b1, 7'h7F, 8'h00, 1'b1, 7'h03, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 40'h00_00_00_22_01};
    vt[10] = '{1'b0, 1'b1, 7'h7F, 8'h00, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 40'h00_07_00_22_01};
    vt[11] = '{1'b0, 1'b1, 7'h05, 8'h55, 1'b1, 7'h7E, 8'h66, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 40'h00_07_00_22_01};

    do_reset();
    @(negedge clk);
    chk("reset_state", {reg_out, busy, a_ack, a_err, b_ack, b_err, commit_done}, 64'h0);

    for (int i = 0; i < 12; i++) begin
      run_vec(vt[i], i);
      if (i == 2) begin
        stay = 1;
        repeat (20) begin
          @(negedge clk);
          if (reg_out !== 40'h00_00_A5_00_00) stay = 0;
        end
        chk("no_commit_reg_stable", 64'(stay), 64'(1));
      end
    end

    do_reset();
    na = 0; nb = 0; pa = 0; pb = 0;
    @(negedge clk);
    a_req = 1'b1; a_addr = 7'h00; a_data = 8'hA0;
    b_req = 1'b1; b_addr = 7'h01; b_data = 8'hB0;
    for (int c = 0; c < 80 && (a_req || b_req); c++) begin
      @(negedge clk);
      if (pa) begin pa = 0; if (na < 4) a_data = 8'hA0 + 8'(na); else a_req = 1'b0; end
      if (pb) begin pb = 0; if (nb < 4) b_data = 8'hB0 + 8'(nb); else b_req = 1'b0; end
      if (a_req && a_ack) begin g.push_back(0); na++; pa = 1; end
      if (b_req && b_ack) begin g.push_back(1); nb++; pb = 1; end
    end
    chk("rr_grant_count", 64'(g.size()), 64'(8));
    for (int i = 0; i < g.size(); i++) chk($sformatf("rr_grant_%0d", i), 64'(g[i]), 64'(i % 2));
    cv = '{1'b0, 1'b1, 7'h7F, 8'h00, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 40'h00_00_00_B3_A3};
    run_vec(cv, 100);

    do_reset();
    @(negedge clk);
    a_req = 1'b1; a_addr = 7'h03; a_data = 8'hFF;
    @(posedge clk);
    #1;
    chk("rst_mid_busy_before", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    chk("rst_mid_no_ack", {a_ack, a_err, busy}, 64'h0);
    @(negedge clk);
    a_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cv = '{1'b0, 1'b1, 7'h7F, 8'h00, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 40'h0};
    run_vec(cv, 101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
